// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the CPU data bus: CTRL/PRESET/COUNT window,
// a 4-state load/count/interrupt sequencer and a maskable interrupt request.
`timescale 1ns/1ps
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  logic [3:0]  ctrl_q,     ctrl_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic [1:0]  state_q,    state_d;
  logic        irq_flag_q, irq_flag_d;

  logic sel_ctrl, sel_preset, sel_count;
  logic wr_ctrl, wr_preset;
  logic flag_set, flag_clr_fsm;

  // Full 32-bit compare against aligned words also rejects misaligned addresses.
  assign sel_ctrl   = (addr == BASE_ADDR);
  assign sel_preset = (addr == BASE_ADDR + 32'd4);
  assign sel_count  = (addr == BASE_ADDR + 32'd8);
  assign hit        = sel_ctrl | sel_preset | sel_count;

  assign wr_ctrl    = we & sel_ctrl;
  assign wr_preset  = we & sel_preset;

  assign irq = irq_flag_q & ctrl_q[3];

  always_comb begin
    rdata = '0;
    if (sel_ctrl)   rdata = {28'd0, ctrl_q};
    if (sel_preset) rdata = preset_q;
    if (sel_count)  rdata = count_q;
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    preset_d     = preset_q;
    count_d      = count_q;
    state_d      = state_q;
    flag_set     = 1'b0;
    flag_clr_fsm = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = ST_INT;
        end
      end
      default: begin
        if (ctrl_q[2:1] == MODE_RELOAD) begin
          flag_clr_fsm = 1'b1;
        end else begin
          ctrl_d[0] = 1'b0;
        end
        state_d = ST_IDLE;
      end
    endcase

    // Bus stores are applied last so a CTRL write overrides the FSM's EN clear.
    if (wr_ctrl)   ctrl_d   = wdata[3:0];
    if (wr_preset) preset_d = wdata;

    if (flag_set) begin
      irq_flag_d = 1'b1;
    end else if (wr_ctrl || wr_preset || flag_clr_fsm) begin
      irq_flag_d = 1'b0;
    end else begin
      irq_flag_d = irq_flag_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: expected values are queued as each step is
// driven and popped when the corresponding DUT output is sampled.
`timescale 1ns/1ps
module tb_timer_dev;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'd4;
  localparam logic [31:0] A_CNT  = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #10 clk = ~clk;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .hit   (hit),
    .irq   (irq)
  );

  task automatic push(input string t, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
    push(t, e);
    addr = a;
    #1;
    pop_cmp(rdata);
    addr = '0;
  endtask

  task automatic chk_irq(input logic e, input string t);
    push(t, {31'd0, e});
    pop_cmp({31'd0, irq});
  endtask

  task automatic chk_hit(input logic [31:0] a, input logic e, input string t);
    push(t, {31'd0, e});
    addr = a;
    #1;
    pop_cmp({31'd0, hit});
    addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    addr  = '0;
    we    = 1'b0;
    wdata = '0;

    #3;
    rd(A_CTRL, 32'd0, "rst_ctrl");
    rd(A_PRE,  32'd0, "rst_pre");
    rd(A_CNT,  32'd0, "rst_cnt");
    chk_irq(1'b0, "rst_irq");
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1);

    chk_hit(A_CTRL,        1'b1, "hit_ctrl");
    chk_hit(A_CNT,         1'b1, "hit_cnt");
    chk_hit(BASE + 32'hC,  1'b0, "hit_off_c");
    chk_hit(BASE + 32'h2,  1'b0, "hit_misalign");

    // One-shot, PRESET=3: COUNT 3,2,1,0 after E2..E5, irq from E5.
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h9);
    cyc(2); rd(A_CNT, 32'd3, "os_cnt_e2");
    cyc(1); rd(A_CNT, 32'd2, "os_cnt_e3");
    cyc(1); rd(A_CNT, 32'd1, "os_cnt_e4"); chk_irq(1'b0, "os_irq_e4");
    cyc(1); rd(A_CNT, 32'd0, "os_cnt_e5"); chk_irq(1'b1, "os_irq_e5");
    cyc(1); rd(A_CTRL, 32'h8, "os_en_clr"); chk_irq(1'b1, "os_irq_e6");
    cyc(2); chk_irq(1'b1, "os_irq_hold");
    wr(A_CTRL, 32'h0);
    chk_irq(1'b0, "os_irq_drop");

    // Undecoded stores must not alter any register.
    wr(BASE + 32'h2, 32'hF);
    wr(BASE + 32'hC, 32'hF);
    rd(A_CTRL, 32'h0, "dec_ctrl");
    rd(A_PRE,  32'd3, "dec_pre");
    rd(BASE + 32'hC, 32'h0, "dec_rdata_c");
    cyc(3);
    rd(A_CNT, 32'd0, "dec_cnt");

    // Auto-reload, PRESET=2: one-cycle irq pulse every 5 cycles from E4.
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      chk_irq((k >= 4) && (((k - 4) % 5) == 0), "ar_irq");
    end
    wr(A_CTRL, 32'h0);
    cyc(3);
    chk_irq(1'b0, "ar_stop");

    // IM=0: flag sets at E3 but irq stays low.
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      chk_irq(1'b0, "mask_irq_low");
    end
    rd(A_CTRL, 32'h0, "mask_en_clr");

    // Setting IM on the same edge the flag sets: set wins, irq high next cycle.
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h1);
    cyc(4);
    rd(A_CNT, 32'd1, "im_cnt_e4");
    chk_irq(1'b0, "im_irq_e4");
    wr(A_CTRL, 32'h9);
    chk_irq(1'b1, "im_irq_set");
    rd(A_CNT, 32'd0, "im_cnt_e5");
    cyc(1);
    rd(A_CTRL, 32'h8, "im_en_clr");
    chk_irq(1'b1, "im_irq_hold");

    // CTRL write in INT beats the FSM's EN clear and clears the flag.
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h1);
    cyc(3);
    wr(A_CTRL, 32'h9);
    rd(A_CTRL, 32'h9, "bus_wins_ctrl");
    chk_irq(1'b0, "bus_clr_flag");
    cyc(2); chk_irq(1'b0, "rearm_irq_e6");
    cyc(1); chk_irq(1'b1, "rearm_irq_e7");
    wr(A_CTRL, 32'h0);
    chk_irq(1'b0, "rearm_clr");

    // Clearing EN freezes COUNT; re-enable reloads PRESET.
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h1);
    cyc(6);
    rd(A_CNT, 32'd6, "frz_e6");
    wr(A_CTRL, 32'h0);
    rd(A_CNT, 32'd5, "frz_e7");
    cyc(3);
    rd(A_CNT, 32'd5, "frz_hold");
    wr(A_CTRL, 32'h1);
    cyc(2); rd(A_CNT, 32'd10, "restart_reload");
    cyc(1); rd(A_CNT, 32'd9, "restart_dec");
    wr(A_PRE, 32'd20);
    rd(A_CNT, 32'd8, "pre_wr_cnt");
    wr(A_CNT, 32'h1234);
    rd(A_CNT, 32'd7, "cnt_wr_ign");
    rd(A_PRE, 32'd20, "pre_new");
    wr(A_CTRL, 32'h0);
    cyc(2);
    rd(A_CNT, 32'd6, "stop_hold");
    wr(A_CTRL, 32'h1);
    cyc(2);
    rd(A_CNT, 32'd20, "next_load");
    cyc(3);
    rd(A_CNT, 32'd17, "pre_rst_cnt");

    // Asynchronous reset mid-count.
    #2;
    reset = 1'b0;
    #1;
    rd(A_CTRL, 32'h0, "arst_ctrl");
    rd(A_PRE,  32'h0, "arst_pre");
    rd(A_CNT,  32'h0, "arst_cnt");
    chk_irq(1'b0, "arst_irq");
    @(posedge clk);
    #1;
    rd(A_CNT, 32'h0, "arst_cnt_held");
    reset = 1'b1;
    cyc(3);
    rd(A_CNT,  32'h0, "post_rst_cnt");
    rd(A_CTRL, 32'h0, "post_rst_ctrl");
    chk_irq(1'b0, "post_rst_irq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
